// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle multiply/divide sequencer that owns HI/LO.
// The result is computed when the op is accepted and parked in pend_hi/pend_lo.
// It is committed to HI/LO only after a fixed busy latency, so the timing
// matches a real iterative unit while the arithmetic stays simple.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_D,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall_req
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               busy_nxt;
  logic [31:0]        hi_nxt, lo_nxt;
  logic [31:0]        pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;

  logic               start_mul_div;
  logic [63:0]        prod_s, prod_u;
  logic               rs_neg, rt_neg;
  logic [31:0]        rs_mag, rt_mag, den_s, den_u;
  logic [31:0]        q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Only mult/multu/div/divu occupy the unit; mthi/mtlo complete in one edge.
  assign start_mul_div = start & ((md_op == OP_MULT) | (md_op == OP_MULTU) |
                                  (md_op == OP_DIV)  | (md_op == OP_DIVU));

  // Freeze F/D while an MD instruction in D would observe a stale or in-flight HI/LO.
  assign stall_req = md_use_D & (busy | start_mul_div);

  // Results of all four arithmetic ops; signed divide is done on magnitudes so
  // that 0x80000000 / -1 wraps cleanly and the remainder follows the dividend sign.
  always_comb begin
    prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u = {32'd0, rs_val} * {32'd0, rt_val};
    rs_neg = rs_val[31];
    rt_neg = rt_val[31];
    rs_mag = rs_neg ? (32'd0 - rs_val) : rs_val;
    rt_mag = rt_neg ? (32'd0 - rt_val) : rt_val;
    den_s  = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
    den_u  = (rt_val == 32'd0) ? 32'd1 : rt_val;
    q_mag  = rs_mag / den_s;
    r_mag  = rs_mag % den_s;
    q_s    = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
    r_s    = rs_neg ? (32'd0 - r_mag) : r_mag;
    q_u    = rs_val / den_u;
    r_u    = rs_val % den_u;
  end

  // Next-state logic: accept ops in IDLE, count down while busy, commit on the last edge.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    busy_nxt    = busy;
    hi_nxt      = hi;
    lo_nxt      = lo;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    case (state)
      IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT: begin
              {pend_hi_nxt, pend_lo_nxt} = prod_s;
              cnt_nxt   = CNT_W'(MULT_CYCLES);
              busy_nxt  = 1'b1;
              state_nxt = MUL;
            end
            OP_MULTU: begin
              {pend_hi_nxt, pend_lo_nxt} = prod_u;
              cnt_nxt   = CNT_W'(MULT_CYCLES);
              busy_nxt  = 1'b1;
              state_nxt = MUL;
            end
            OP_DIV: begin
              if (rt_val == 32'd0) begin
                pend_hi_nxt = hi;
                pend_lo_nxt = lo;
              end else begin
                pend_hi_nxt = r_s;
                pend_lo_nxt = q_s;
              end
              cnt_nxt   = CNT_W'(DIV_CYCLES);
              busy_nxt  = 1'b1;
              state_nxt = DIV;
            end
            OP_DIVU: begin
              if (rt_val == 32'd0) begin
                pend_hi_nxt = hi;
                pend_lo_nxt = lo;
              end else begin
                pend_hi_nxt = r_u;
                pend_lo_nxt = q_u;
              end
              cnt_nxt   = CNT_W'(DIV_CYCLES);
              busy_nxt  = 1'b1;
              state_nxt = DIV;
            end
            OP_MTHI: hi_nxt = rs_val;
            OP_MTLO: lo_nxt = rs_val;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          hi_nxt    = pend_hi;
          lo_nxt    = pend_lo;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and HI/LO registers; an active-low reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      busy    <= busy_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
    end
  end

endmodule
